// File: rtl/gbt_rx_frame_monitor_if.sv
// gbt_rx_frame_monitor_if: received GBT frame in, validated motor data out
interface gbt_rx_frame_monitor_if;
  logic        frame_valid_i;
  logic [79:0] payload_i;
  logic [63:0] data_o;
  logic        data_valid_o;
  modport master(output frame_valid_i, payload_i, input data_o, data_valid_o);
  modport slave(input frame_valid_i, payload_i, output data_o, data_valid_o);
endinterface

// File: rtl/gbt_rx_frame_monitor.sv
// gbt_rx_frame_monitor: checks GBT frames, qualifies link lock, forwards validated motor data
module gbt_rx_frame_monitor #(
  parameter int         LOCK_FRAMES    = 16,
  parameter int         UNLOCK_ERRORS  = 4,
  parameter int         TIMEOUT_CYCLES = 4000,
  parameter logic [3:0] HEADER         = 4'hA
) (
  input  logic                     clk_40mhz,
  input  logic                     reset_n,
  input  logic                     rx_ready_i,
  input  logic                     link_ready_i,
  input  logic                     clear_cnt_i,
  gbt_rx_frame_monitor_if.slave    bus,
  output logic [1:0]               link_state_o,
  output logic                     locked_o,
  output logic [15:0]              hdr_err_cnt_o,
  output logic [15:0]              seq_err_cnt_o,
  output logic [15:0]              crc_err_cnt_o,
  output logic                     timeout_o
);
  typedef enum logic [1:0] {LINK_DOWN = 2'd0, SYNCING = 2'd1, LOCKED = 2'd2} state_t;
  localparam int RW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  state_t          r_state, w_state_nx;
  logic [RW-1:0]   r_run, w_run_nx;
  logic [BW-1:0]   r_bad, w_bad_nx;
  logic [WW-1:0]   r_wd;
  logic [3:0]      r_exp_seq;
  logic [63:0]     r_data;
  logic            r_dv, r_timeout, w_strobe;
  logic [15:0]     r_hdr_cnt, r_seq_cnt, r_crc_cnt;
  logic            w_active, w_fv, w_ready, w_timeout;
  logic            w_hdr_ok, w_crc_ok, w_seq_ok, w_good;
  logic [7:0]      w_xor;
  wire [79:0] w_p = bus.payload_i;
  assign w_xor    = w_p[63:56] ^ w_p[55:48] ^ w_p[47:40] ^ w_p[39:32] ^
                    w_p[31:24] ^ w_p[23:16] ^ w_p[15:8]  ^ w_p[7:0];
  assign w_active = r_state != LINK_DOWN;
  assign w_fv     = bus.frame_valid_i & w_active;
  assign w_ready  = rx_ready_i & link_ready_i;
  assign w_hdr_ok = w_p[79:76] == HEADER;
  assign w_crc_ok = w_p[71:64] == w_xor;
  assign w_seq_ok = w_p[75:72] == r_exp_seq;
  assign w_good   = w_hdr_ok & w_crc_ok & w_seq_ok;
  assign w_timeout = w_active & ~bus.frame_valid_i & (r_wd == WW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    w_bad_nx   = r_bad;
    w_strobe   = 1'b0;
    case (r_state)
      LINK_DOWN: if (w_ready) begin
        w_state_nx = SYNCING;
        w_run_nx   = '0;
      end
      SYNCING: if (w_fv) begin
        w_run_nx = w_good ? r_run + 1'b1 : '0;
        if (w_good && r_run == RW'(LOCK_FRAMES - 1)) begin
          w_state_nx = LOCKED;
          w_bad_nx   = '0;
          w_strobe   = 1'b1;
        end
      end
      LOCKED: if (w_fv) begin
        w_bad_nx = w_good ? '0 : r_bad + 1'b1;
        w_strobe = w_good;
        if (!w_good && r_bad == BW'(UNLOCK_ERRORS - 1)) begin
          w_state_nx = SYNCING;
          w_run_nx   = '0;
        end
      end
      default: w_state_nx = LINK_DOWN;
    endcase
    if (!w_ready || w_timeout) w_state_nx = LINK_DOWN;
  end
  function automatic logic [15:0] f_cnt(input logic [15:0] c, input logic inc, input logic clr);
    return clr ? 16'd0 : c + {15'd0, inc & ~&c};
  endfunction
  always_ff @(posedge clk_40mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= LINK_DOWN;
      r_run     <= '0;
      r_bad     <= '0;
      r_wd      <= '0;
      r_exp_seq <= '0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_timeout <= 1'b0;
      r_hdr_cnt <= '0;
      r_seq_cnt <= '0;
      r_crc_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_run     <= w_run_nx;
      r_bad     <= w_bad_nx;
      r_dv      <= w_strobe;
      r_wd      <= (!w_active || bus.frame_valid_i || w_timeout) ? '0 : r_wd + 1'b1;
      if (w_strobe) r_data <= w_p[63:0];
      // resync to the sender's count whenever the frame itself is trustworthy
      if (w_fv && w_hdr_ok && w_crc_ok) r_exp_seq <= w_p[75:72] + 4'd1;
      r_hdr_cnt <= f_cnt(r_hdr_cnt, w_fv & ~w_hdr_ok, clear_cnt_i);
      r_crc_cnt <= f_cnt(r_crc_cnt, w_fv & ~w_crc_ok, clear_cnt_i);
      r_seq_cnt <= f_cnt(r_seq_cnt, w_fv & w_hdr_ok & w_crc_ok & ~w_seq_ok, clear_cnt_i);
      r_timeout <= clear_cnt_i ? 1'b0 : (r_timeout | w_timeout);
    end
  end
  assign bus.data_o       = r_data;
  assign bus.data_valid_o = r_dv;
  assign link_state_o     = r_state;
  assign locked_o         = r_state == LOCKED;
  assign hdr_err_cnt_o    = r_hdr_cnt;
  assign seq_err_cnt_o    = r_seq_cnt;
  assign crc_err_cnt_o    = r_crc_cnt;
  assign timeout_o        = r_timeout;
endmodule
